// File: rtl/ahb_master_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_master_ctrl
//   AHB-Lite master transfer sequencer. It takes one transfer command at a
//   time and drives the matching address phases on the bus: SINGLE, INCR4,
//   INCR8 or INCR16, with byte, half-word or word size. It also steps the
//   register-file byte index (rf_idx) so the master register file stores
//   read data, or supplies HWDATA, one beat at a time.
//
//   Commands are rejected at acceptance if any of these hold:
//   - the size or burst encoding is illegal;
//   - the start address is not aligned to the transfer size;
//   - the burst would cross a 1KB boundary.
//
//   A two-cycle ERROR response cancels the rest of the burst.
//
// Ports
//   HCLK, HRESETn            bus clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_write, cmd_addr,
//   cmd_size, cmd_burst,
//   cmd_rf_idx               command fields
//   HADDR, HTRANS, HWRITE,
//   HSIZE, HBURST, HPROT,
//   HMASTLOCK                AHB-Lite address/control outputs
//   HREADY, HRESP            slave response
//   rf_idx                   register-file byte index (A1)
//   irq_flag                 one-cycle pulse after a bus ERROR
//   done                     one-cycle pulse after successful completion
//   cmd_err                  one-cycle pulse after a rejected command
// ---------------------------------------------------------------------------
module ahb_master_ctrl #(
   parameter int          ADDR_W    = 32,
   parameter int          RF_AW     = 8,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [2:0]        cmd_burst,
   input  logic [RF_AW-1:0]  cmd_rf_idx,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic              HMASTLOCK,
   input  logic              HREADY,
   input  logic              HRESP,
   output logic [RF_AW-1:0]  rf_idx,
   output logic              irq_flag,
   output logic              done,
   output logic              cmd_err
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR1} state_t;

   state_t             state_reg, state_next;

   logic               first_reg;    // next address phase on the bus is the NONSEQ one
   logic               dp_reg;       // a data phase is outstanding this cycle
   logic [3:0]         cnt_reg;      // address phases still to issue after the current one
   logic [RF_AW-1:0]   rf_base_reg;
   logic               done_reg, irq_reg, cmd_err_reg;

   // ---------------- command legality check ----------------
   logic               size_ok, burst_ok, aligned, crosses, illegal;
   logic               accept, reject;
   logic [3:0]         beats_m1;
   logic [ADDR_W-1:0]  cmd_inc, last_addr;

   always_comb begin
      size_ok  = (cmd_size == 3'b000) || (cmd_size == 3'b001) || (cmd_size == 3'b010);
      burst_ok = 1'b1;
      beats_m1 = 4'd0;
      case (cmd_burst)
         3'b000:  beats_m1 = 4'd0;
         3'b011:  beats_m1 = 4'd3;
         3'b101:  beats_m1 = 4'd7;
         3'b111:  beats_m1 = 4'd15;
         default: burst_ok = 1'b0;
      endcase
      cmd_inc   = ADDR_W'(1) << cmd_size;
      aligned   = (cmd_addr & (cmd_inc - ADDR_W'(1))) == '0;
      last_addr = cmd_addr + (ADDR_W'(beats_m1) << cmd_size);
      // Any difference above bit 9 means the burst leaves its 1KB page.
      crosses   = last_addr[ADDR_W-1:10] != cmd_addr[ADDR_W-1:10];
      illegal   = !size_ok || !burst_ok || !aligned || crosses;
      accept    = cmd_valid && cmd_ready && !illegal;
      reject    = cmd_valid && cmd_ready && illegal;
   end

   // ---------------- bus events ----------------
   logic               addr_done, data_ok, data_err;
   logic [ADDR_W-1:0]  haddr_inc;
   logic [RF_AW-1:0]   rf_inc;

   always_comb begin
      addr_done = (state_reg == S_ADDR) && HREADY;
      data_ok   = dp_reg && HREADY && !HRESP;
      // The first cycle of a two-cycle ERROR response.
      data_err  = dp_reg && HRESP && !HREADY;
      haddr_inc = ADDR_W'(1) << HSIZE;
      rf_inc    = RF_AW'(1) << HSIZE;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (accept) state_next = S_ADDR;
         S_ADDR: begin
            if (data_err)
               state_next = S_ERR1;
            else if (HREADY && cnt_reg == 4'd0)
               state_next = S_LAST;
         end
         S_LAST: begin
            if (data_err)
               state_next = S_ERR1;
            else if (HREADY)
               state_next = S_IDLE;
         end
         S_ERR1: if (HREADY) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      HTRANS    = TRANS_IDLE;
      if (state_reg == S_ADDR)
         HTRANS = first_reg ? TRANS_NONSEQ : TRANS_SEQ;
      // Stay busy during the cycle a completion or reject pulse is shown.
      cmd_ready = (state_reg == S_IDLE) && !done_reg && !irq_reg && !cmd_err_reg;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         HADDR       <= '0;
         HWRITE      <= 1'b0;
         HSIZE       <= 3'b010;
         HBURST      <= 3'b000;
         first_reg   <= 1'b0;
         dp_reg      <= 1'b0;
         cnt_reg     <= 4'd0;
         rf_base_reg <= '0;
         rf_idx      <= '0;
         done_reg    <= 1'b0;
         irq_reg     <= 1'b0;
         cmd_err_reg <= 1'b0;
      end else begin
         if (accept) begin
            HADDR       <= cmd_addr;
            HWRITE      <= cmd_write;
            HSIZE       <= cmd_size;
            HBURST      <= cmd_burst;
            cnt_reg     <= beats_m1;
            rf_base_reg <= cmd_rf_idx;
            first_reg   <= 1'b1;
         end else if (addr_done) begin
            first_reg <= 1'b0;
            if (cnt_reg != 4'd0) begin
               HADDR   <= HADDR + haddr_inc;
               cnt_reg <= cnt_reg - 4'd1;
            end
         end

         // A completed address phase opens the data phase of that beat.
         if (addr_done)
            dp_reg <= 1'b1;
         else if (HREADY)
            dp_reg <= 1'b0;

         if (addr_done && first_reg)
            rf_idx <= rf_base_reg;
         else if (data_ok)
            rf_idx <= rf_idx + rf_inc;

         done_reg    <= (state_reg == S_LAST) && HREADY && !HRESP;
         irq_reg     <= (state_reg == S_ERR1) && HREADY;
         cmd_err_reg <= reject;
      end
   end

   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;
   assign done      = done_reg;
   assign irq_flag  = irq_reg;
   assign cmd_err   = cmd_err_reg;

endmodule

// File: doc/ahb_master_ctrl.md
Name: ahb_master_ctrl

Overview:
- AHB-Lite master transfer sequencer; sits directly upstream of the master register file.
- Accepts one transfer command (address, direction, size, burst type, local register index) and drives the AHB-Lite address phase on the bus.
- Steps the register-file byte index (A1) and direction so the register file stores read data or supplies HWDATA beat by beat.
- Handles wait states, ERROR responses and 1KB-boundary / alignment checks.

Parameters:
- ADDR_W, 32, AHB address width.
- RF_AW, 8, register-file byte-index width (256 entries).
- HPROT_VAL, 4'b0011, constant HPROT (non-cacheable, privileged data).

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low. Clock is HCLK.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = bus write, 0 = bus read.
- cmd_addr  in  ADDR_W  start address.
- cmd_size  in  3  HSIZE_E: BYTE=000, HALF_WORD=001, WORD=010; other values are illegal.
- cmd_burst  in  3  SINGLE=000, INCR4=011, INCR8=101, INCR16=111; other values are illegal.
- cmd_rf_idx  in  RF_AW  register-file base byte index.
- HADDR  out  ADDR_W  bus address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11 (BUSY is never driven).
- HWRITE  out  1  bus direction; also feeds register file HWRITE.
- HSIZE  out  3  bus size; also feeds register file HSIZE.
- HBURST  out  3  burst type.
- HPROT  out  4  = HPROT_VAL.
- HMASTLOCK  out  1  tied 0.
- HREADY  in  1  slave ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.
- rf_idx  out  RF_AW  register-file A1.
- irq_flag  out  1  one-cycle pulse on bus error; drives register file INTERRUPT_FLAG.
- done  out  1  one-cycle pulse on successful completion.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset values:
  - HTRANS = 00, HADDR = 0, HWRITE = 0, HSIZE = 010, HBURST = 000.
  - rf_idx = 0, cmd_ready = 1, done = irq_flag = cmd_err = 0.
  - FSM = IDLE.
- Reset asserted mid-burst aborts immediately to the reset values; no completion pulse is issued.
- Beats: SINGLE = 1, INCR4 = 4, INCR8 = 8, INCR16 = 16. Increment INC = 1 << cmd_size.
- Reject check at acceptance, evaluated in the same cycle the command is accepted. The command is rejected if any of the following holds:
  - illegal size or burst encoding;
  - cmd_addr not aligned to INC;
  - last beat address (cmd_addr + (beats-1)*INC) differs from cmd_addr in bits [ADDR_W-1:10], i.e. the burst crosses a 1KB boundary.
- On reject: cmd_err pulses the next cycle, FSM stays IDLE, no bus activity.
- FSM states:
  - IDLE: HTRANS = IDLE. On a legal command, capture all fields; next cycle go to ADDR with HTRANS = NONSEQ and HADDR = cmd_addr.
  - ADDR: an address phase completes at a rising edge with HREADY = 1. While HREADY = 0, HADDR, HTRANS, HSIZE, HBURST and HWRITE are held stable.
    - On completion with beats remaining: next HADDR += INC, HTRANS = SEQ.
    - On completion of the last address: HTRANS = IDLE, go to LAST.
  - LAST: wait for the final data phase. HREADY = 1 & HRESP = 0 → done pulses the next cycle, go to IDLE.
  - ERR1: entered when HRESP = 1 & HREADY = 0 in any data phase.
    - Next cycle drives HTRANS = IDLE, cancelling all remaining beats.
    - When HREADY = 1 (second error cycle), go to IDLE and pulse irq_flag and done = 0.
- rf_idx:
  - Loaded with cmd_rf_idx when the first address phase completes.
  - Advances by INC at each edge where a data phase completes (HREADY = 1, HRESP = 0), modulo 2^RF_AW (wraps 255 → 0).
- Data-phase tracking: one data phase is outstanding at most, the standard AHB-Lite pipeline. Address phase of beat n+1 overlaps the data phase of beat n.
- cmd_ready is low from acceptance until the cycle after done, irq_flag or cmd_err. No commands overlap.
- Latency: a SINGLE transfer with zero wait states gives done 3 cycles after acceptance (NONSEQ, data, done).

Test Plan:
1. WORD SINGLE write, addr 0x100, rf_idx 4, HREADY = 1 → one NONSEQ at 0x100, HWRITE = 1, HTRANS = IDLE next; done pulses 3 cycles after acceptance; rf_idx ends at 8.
2. WORD INCR4 read at 0x200, HREADY low 2 cycles on beat 2 → HADDR 0x200/0x204/0x208/0x20C with SEQ after the first; HADDR held during the wait; rf_idx steps 0, 4, 8, 12, 16; one done.
3. HALF_WORD INCR8 at 0x3F8 → crosses 1KB; cmd_err pulses; HTRANS stays 00; cmd_ready returns high.
4. WORD INCR16 at 0x000; slave gives ERROR on beat 3 (HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1) → HTRANS = IDLE in the second error cycle; no further SEQ; irq_flag pulses once; done never pulses.
5. Misaligned WORD at 0x102, and cmd_size = 011 → both rejected with cmd_err.
6. HRESETn low during beat 5 of INCR8 → all outputs return to reset values asynchronously; a new SINGLE after release completes normally.
